// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the serial FIR sample stream and the parallel FFT core.
// Collects N_PTS samples per bank, zero-pads flushed partial frames, and counts consumed frames.
module fft_frame_buffer #(
    parameter int DATA_W     = 16,
    parameter int N_PTS      = 16,
    parameter int NUM_FRAMES = 64,
    localparam int CNT_W     = $clog2(NUM_FRAMES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fir_valid,
    input  logic [DATA_W-1:0]       fir_d,
    input  logic                    fir_flush,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [N_PTS*DATA_W-1:0] frame_d,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic                    overflow,
    output logic                    done
);

    localparam int IDX_W = $clog2(N_PTS);

    logic [DATA_W-1:0] mem [2][N_PTS];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [IDX_W-1:0]  wr_idx;

    logic              wr_full;
    logic              accept;
    logic              last;
    logic              flush_eff;
    logic              close;
    logic              hs;
    logic [IDX_W:0]    pad_start;

    // A flush pads from the lane after any sample stored this same cycle;
    // it is ignored when nothing would remain in the frame but padding.
    always_comb begin
        wr_full   = full[wr_bank];
        accept    = fir_valid && !wr_full;
        last      = accept && (wr_idx == IDX_W'(N_PTS - 1));
        pad_start = {1'b0, wr_idx} + {{IDX_W{1'b0}}, accept};
        flush_eff = fir_flush && !wr_full && !last && (pad_start != '0);
        close     = last || flush_eff;
        hs        = full[rd_bank] && frame_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_PTS; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N_PTS; i++) begin
                if (accept && (wr_idx == IDX_W'(i))) begin
                    mem[wr_bank][i] <= fir_d;
                end else if (flush_eff && ((IDX_W+1)'(i) >= pad_start)) begin
                    mem[wr_bank][i] <= '0;
                end
            end
        end
    end

    // Closing a frame and handing one off always touch different banks:
    // a closable write bank is empty, a handed-off read bank is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (close) begin
                wr_idx        <= '0;
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end else if (accept) begin
                wr_idx <= wr_idx + 1'b1;
            end

            if (hs) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                if (frame_cnt != CNT_W'(NUM_FRAMES)) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                if (frame_cnt == CNT_W'(NUM_FRAMES - 1)) begin
                    done <= 1'b1;
                end
            end

            if (fir_valid && wr_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        frame_valid = full[rd_bank];
        frame_d     = '0;
        if (full[rd_bank]) begin
            for (int i = 0; i < N_PTS; i++) begin
                frame_d[i*DATA_W +: DATA_W] = mem[rd_bank][i];
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: constant vector table, directed corner sequences,
// and a randomized run, all cross-checked every cycle against a frame-queue model.
module tb_fft_frame_buffer;

    localparam int DATA_W     = 16;
    localparam int N_PTS      = 16;
    localparam int NUM_FRAMES = 64;
    localparam int FW         = N_PTS * DATA_W;
    localparam int CNT_W      = $clog2(NUM_FRAMES + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              fir_valid;
    logic [DATA_W-1:0] fir_d;
    logic              fir_flush;
    logic              frame_valid;
    logic              frame_ready;
    logic [FW-1:0]     frame_d;
    logic [CNT_W-1:0]  frame_cnt;
    logic              overflow;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model: a two-deep FIFO of completed frames plus the partial frame being collected.
    logic [DATA_W-1:0] part_q[$];
    logic [FW-1:0]     pend_q[$];
    int                m_cnt;
    logic              m_ovf;
    logic              m_done;

    typedef struct {
        logic              vld;
        logic [DATA_W-1:0] d;
        logic              fl;
        logic              rdy;
        logic              exp_fv;
        logic [DATA_W-1:0] exp_l0;
        logic [DATA_W-1:0] exp_l15;
        int                exp_cnt;
    } vec_t;

    vec_t vecs[17];

    fft_frame_buffer #(
        .DATA_W    (DATA_W),
        .N_PTS     (N_PTS),
        .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d),
        .fir_flush  (fir_flush),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_d    (frame_d),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] lane(input int i);
        return frame_d[i*DATA_W +: DATA_W];
    endfunction

    task automatic check_output(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        pend_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic close_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < part_q.size(); i++) f[i*DATA_W +: DATA_W] = part_q[i];
        pend_q.push_back(f);
        part_q.delete();
    endtask

    task automatic model_edge();
        int n_pend;
        n_pend = pend_q.size();
        if (n_pend > 0 && frame_ready) begin
            void'(pend_q.pop_front());
            if (m_cnt < NUM_FRAMES) m_cnt++;
            if (m_cnt == NUM_FRAMES) m_done = 1'b1;
        end
        if (fir_valid) begin
            if (n_pend == 2) begin
                m_ovf = 1'b1;
            end else begin
                part_q.push_back(fir_d);
                if (part_q.size() == N_PTS || fir_flush) close_frame();
            end
        end else if (fir_flush && part_q.size() > 0) begin
            close_frame();
        end
    endtask

    task automatic check_model();
        logic [FW-1:0] exp_d;
        exp_d = (pend_q.size() > 0) ? pend_q[0] : '0;
        check_output("frame_valid", FW'(frame_valid), FW'(pend_q.size() > 0));
        check_output("frame_d", frame_d, exp_d);
        check_output("frame_cnt", FW'(frame_cnt), FW'(m_cnt));
        check_output("overflow", FW'(overflow), FW'(m_ovf));
        check_output("done", FW'(done), FW'(m_done));
    endtask

    task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d, input logic fl, input logic rdy);
        fir_valid   = v;
        fir_d       = d;
        fir_flush   = fl;
        frame_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        check_model();
    endtask

    task automatic do_reset();
        fir_valid   = 1'b0;
        fir_d       = '0;
        fir_flush   = 1'b0;
        frame_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_output("rst_frame_valid", FW'(frame_valid), '0);
        check_output("rst_frame_d", frame_d, '0);
        check_output("rst_frame_cnt", FW'(frame_cnt), '0);
        check_output("rst_overflow", FW'(overflow), '0);
        check_output("rst_done", FW'(done), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].vld     = 1'b1;
            vecs[i].d       = DATA_W'(i + 1);
            vecs[i].fl      = 1'b0;
            vecs[i].rdy     = 1'b1;
            vecs[i].exp_fv  = (i == 15);
            vecs[i].exp_l0  = (i == 15) ? 16'h0001 : 16'h0000;
            vecs[i].exp_l15 = (i == 15) ? 16'h0010 : 16'h0000;
            vecs[i].exp_cnt = 0;
        end
        vecs[16] = '{vld: 1'b0, d: 16'h0000, fl: 1'b0, rdy: 1'b1,
                     exp_fv: 1'b0, exp_l0: 16'h0000, exp_l15: 16'h0000, exp_cnt: 1};

        do_reset();

        for (int r = 0; r < 17; r++) begin
            apply_stimulus(vecs[r].vld, vecs[r].d, vecs[r].fl, vecs[r].rdy);
            check_output("vec_frame_valid", FW'(frame_valid), FW'(vecs[r].exp_fv));
            check_output("vec_lane0", FW'(lane(0)), FW'(vecs[r].exp_l0));
            check_output("vec_lane15", FW'(lane(15)), FW'(vecs[r].exp_l15));
            check_output("vec_frame_cnt", FW'(frame_cnt), FW'(vecs[r].exp_cnt));
        end
        check_output("vec_overflow", FW'(overflow), '0);

        // Continuous stream up to done
        do_reset();
        for (int k = 0; k < 1024; k++) apply_stimulus(1'b1, DATA_W'(k + 1), 1'b0, 1'b1);
        repeat (2) apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("stream_frame_cnt", FW'(frame_cnt), FW'(64));
        check_output("stream_done", FW'(done), FW'(1));
        check_output("stream_overflow", FW'(overflow), '0);

        // Consumer stalls across two full banks
        for (int k = 0; k < 33; k++) apply_stimulus(1'b1, DATA_W'(16'h0100 + k), 1'b0, 1'b0);
        check_output("stall_overflow", FW'(overflow), FW'(1));
        check_output("stall_valid", FW'(frame_valid), FW'(1));
        check_output("stall_first_lane0", FW'(lane(0)), FW'(16'h0100));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("stall_second_lane0", FW'(lane(0)), FW'(16'h0110));
        check_output("stall_second_lane15", FW'(lane(15)), FW'(16'h011F));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("stall_drained", FW'(frame_valid), '0);

        // Flush of a 5-sample partial frame, then a flush with nothing collected
        for (int k = 0; k < 5; k++) apply_stimulus(1'b1, DATA_W'(16'h00A0 + k), 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("flush_valid", FW'(frame_valid), FW'(1));
        check_output("flush_lane0", FW'(lane(0)), FW'(16'h00A0));
        check_output("flush_lane4", FW'(lane(4)), FW'(16'h00A4));
        check_output("flush_lane5", FW'(lane(5)), '0);
        check_output("flush_lane15", FW'(lane(15)), '0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("empty_flush_no_frame", FW'(frame_valid), '0);

        // Flush coincident with the 15th sample
        for (int k = 0; k < 14; k++) apply_stimulus(1'b1, DATA_W'(16'h00B0 + k), 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h00BE, 1'b1, 1'b0);
        check_output("coflush_valid", FW'(frame_valid), FW'(1));
        check_output("coflush_lane13", FW'(lane(13)), FW'(16'h00BD));
        check_output("coflush_lane14", FW'(lane(14)), FW'(16'h00BE));
        check_output("coflush_lane15", FW'(lane(15)), '0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame with a frame pending
        for (int k = 0; k < 25; k++) apply_stimulus(1'b1, DATA_W'(16'h00C0 + k), 1'b0, 1'b0);
        check_output("prereset_valid", FW'(frame_valid), FW'(1));
        do_reset();
        for (int k = 0; k < 16; k++) apply_stimulus(1'b1, DATA_W'(16'h00D0 + k), 1'b0, 1'b0);
        check_output("postreset_valid", FW'(frame_valid), FW'(1));
        check_output("postreset_lane0", FW'(lane(0)), FW'(16'h00D0));
        check_output("postreset_lane15", FW'(lane(15)), FW'(16'h00DF));

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            apply_stimulus($urandom_range(0, 9) < 7, DATA_W'($urandom),
                           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
